// File: rtl/selector_scan.sv
// selector_scan: N-channel registered data selector with manual index selection
// and a masked, dwell-timed automatic scan for display/monitor paths.
module selector_scan #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4,
  localparam int unsigned SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic [CHANNELS*WIDTH-1:0] iData,
  input  logic [SELW-1:0]           iSel,
  input  logic                      iMode,
  input  logic [CHANNELS-1:0]       iMask,
  input  logic                      iHold,
  output logic [WIDTH-1:0]          oZ,
  output logic [SELW-1:0]           oCh,
  output logic                      oValid,
  output logic                      oWrap
);

  localparam int unsigned CNTW = $clog2(DWELL + 1);

  logic [SELW-1:0]  ptr;
  logic [CNTW-1:0]  cnt;
  logic             modeQ;

  logic             ptrEn;
  logic             anyEn;
  logic             aboveEn;
  logic [SELW-1:0]  lowest;
  logic [SELW-1:0]  above;
  logic [SELW-1:0]  nextPtr;

  logic [SELW-1:0]  ptrD;
  logic [CNTW-1:0]  cntD;
  logic             validD;
  logic             wrapD;
  logic [WIDTH-1:0] zD;

  // Next enabled channel after ptr: first enabled above ptr, else wrap to lowest enabled.
  always_comb begin
    ptrEn   = 1'b0;
    anyEn   = 1'b0;
    aboveEn = 1'b0;
    lowest  = '0;
    above   = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (iMask[k] && SELW'(k) == ptr) ptrEn = 1'b1;
      if (iMask[k] && !anyEn) begin
        lowest = SELW'(k);
        anyEn  = 1'b1;
      end
      if (iMask[k] && !aboveEn && SELW'(k) > ptr) begin
        above   = SELW'(k);
        aboveEn = 1'b1;
      end
    end
    nextPtr = aboveEn ? above : lowest;
  end

  // Mode/scan decision: a restart (entry, idle count, disabled ptr) outranks hold.
  always_comb begin
    ptrD   = ptr;
    cntD   = cnt;
    validD = 1'b0;
    wrapD  = 1'b0;
    if (!iMode) begin
      ptrD   = iSel;
      cntD   = '0;
      validD = (32'(iSel) < CHANNELS);
    end else if (!anyEn) begin
      cntD = '0;
    end else if (!modeQ || cnt == '0 || !ptrEn) begin
      ptrD   = ptrEn ? ptr : nextPtr;
      cntD   = CNTW'(1);
      validD = 1'b1;
      wrapD  = !ptrEn && (nextPtr <= ptr);
    end else if (iHold) begin
      validD = 1'b1;
    end else if (cnt == CNTW'(DWELL)) begin
      ptrD   = nextPtr;
      cntD   = CNTW'(1);
      validD = 1'b1;
      wrapD  = (nextPtr <= ptr);
    end else begin
      cntD   = cnt + CNTW'(1);
      validD = 1'b1;
    end
  end

  // Data mux on the upcoming pointer so oZ tracks live data with one cycle latency.
  always_comb begin
    zD = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (validD && SELW'(k) == ptrD) zD = iData[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      ptr    <= '0;
      cnt    <= '0;
      modeQ  <= 1'b0;
      oZ     <= '0;
      oValid <= 1'b0;
      oWrap  <= 1'b0;
    end else begin
      ptr    <= ptrD;
      cnt    <= cntD;
      modeQ  <= iMode;
      oZ     <= zD;
      oValid <= validD;
      oWrap  <= wrapD;
    end
  end

  assign oCh = ptr;

endmodule

// File: tb/tb_selector_scan.sv
// Bench for selector_scan: behavioural model feeds a scoreboard queue each edge;
// scenario tasks pop and compare, plus fixed sequences for the key scenarios.
module tb_selector_scan;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [3:0] z;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        iReset;
  logic [15:0] iData;
  logic [1:0]  iSel;
  logic        iMode;
  logic [3:0]  iMask;
  logic        iHold;
  logic [3:0]  oZ;
  logic [1:0]  oCh;
  logic        oValid;
  logic        oWrap;

  logic [11:0] iData1;
  logic [1:0]  iSel1;
  logic        iMode1;
  logic [2:0]  iMask1;
  logic        iHold1;
  logic [3:0]  oZ1;
  logic [1:0]  oCh1;
  logic        oValid1;
  logic        oWrap1;

  int   vectors = 0;
  int   miscompares = 0;
  int   mPtr = 0;
  int   mCnt = 0;
  logic mModeQ = 1'b0;
  exp_t sbQ[$];

  selector_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(4)) u0 (
    .iClk(clk), .iReset(iReset), .iData(iData), .iSel(iSel), .iMode(iMode),
    .iMask(iMask), .iHold(iHold), .oZ(oZ), .oCh(oCh), .oValid(oValid), .oWrap(oWrap)
  );

  selector_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) u1 (
    .iClk(clk), .iReset(iReset), .iData(iData1), .iSel(iSel1), .iMode(iMode1),
    .iMask(iMask1), .iHold(iHold1), .oZ(oZ1), .oCh(oCh1), .oValid(oValid1), .oWrap(oWrap1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: got no finish, required finish");
    $fatal(1);
  end

  function automatic int mNext(int p, logic [3:0] m);
    for (int off = 1; off <= int'(CH); off++) begin
      int i;
      i = (p + off) % int'(CH);
      if (m[i]) return i;
    end
    return p;
  endfunction

  task automatic modelEdge(output exp_t e);
    int   old;
    logic v;
    logic w;
    v = 1'b0;
    w = 1'b0;
    if (iReset) begin
      mPtr = 0; mCnt = 0; mModeQ = 1'b0;
      e = '0;
      return;
    end
    if (!iMode) begin
      mPtr = int'(iSel); mCnt = 0; v = 1'b1;
    end else if (iMask == 4'h0) begin
      mCnt = 0;
    end else begin
      old = mPtr;
      v = 1'b1;
      if (!mModeQ || mCnt == 0 || !iMask[mPtr]) begin
        if (!iMask[mPtr]) begin
          mPtr = mNext(old, iMask);
          w = (mPtr <= old);
        end
        mCnt = 1;
      end else if (iHold) begin
        mCnt = mCnt;
      end else if (mCnt == int'(DW)) begin
        mPtr = mNext(old, iMask);
        mCnt = 1;
        w = (mPtr <= old);
      end else begin
        mCnt = mCnt + 1;
      end
    end
    mModeQ = iMode;
    e.ch = 2'(mPtr);
    e.valid = v;
    e.wrap = w;
    e.z = v ? iData[mPtr*4 +: 4] : 4'h0;
  endtask

  task automatic tick();
    exp_t e;
    modelEdge(e);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t got;
    iReset = 1'b1; iData = 16'hDCBA; iMode = 1'b1; iMask = 4'hF; iHold = 1'b0; iSel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL reset_sb[%0d] got=%h exp=%h", i, got, e); end
      vectors++;
      if (got !== 8'h00) begin miscompares++; $display("FAIL reset_zero[%0d] got=%h exp=00", i, got); end
    end
    iReset = 1'b0;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL release_sb got=%h exp=%h", got, e); end
    vectors++;
    if ({oZ, oCh, oValid} !== {4'hA, 2'd0, 1'b1}) begin
      miscompares++; $display("FAIL release z=%h ch=%0d v=%b exp z=a ch=0 v=1", oZ, oCh, oValid);
    end
  endtask

  task automatic test_manual();
    exp_t e;
    exp_t got;
    iMode = 1'b0; iSel = 2'd2; iData = 16'hDCBA;
    iSel1 = 2'd3; iData1 = 12'h987;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL manual_sb got=%h exp=%h", got, e); end
    vectors++;
    if ({oZ, oCh, oValid} !== {4'hC, 2'd2, 1'b1}) begin
      miscompares++; $display("FAIL manual_sel2 z=%h ch=%0d v=%b exp z=c ch=2 v=1", oZ, oCh, oValid);
    end
    vectors++;
    if ({oZ1, oCh1, oValid1} !== {4'h0, 2'd3, 1'b0}) begin
      miscompares++; $display("FAIL manual_oor z=%h ch=%0d v=%b exp z=0 ch=3 v=0", oZ1, oCh1, oValid1);
    end
    iData[11:8] = 4'h5; iSel1 = 2'd1;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL manual_live_sb got=%h exp=%h", got, e); end
    vectors++;
    if (oZ !== 4'h5) begin miscompares++; $display("FAIL manual_live z=%h exp=5", oZ); end
    vectors++;
    if ({oZ1, oCh1, oValid1} !== {4'h8, 2'd1, 1'b1}) begin
      miscompares++; $display("FAIL manual_c3 z=%h ch=%0d v=%b exp z=8 ch=1 v=1", oZ1, oCh1, oValid1);
    end
    for (int i = 0; i < 8; i++) begin
      iSel = 2'($urandom_range(3)); iData = 16'($urandom);
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL manual_rand[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_scan_full();
    exp_t e;
    exp_t got;
    int seqCh[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    iMode = 1'b0; iSel = 2'd0; iData = 16'hDCBA;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL full_pre_sb got=%h exp=%h", got, e); end
    iMode = 1'b1; iMask = 4'hF;
    for (int i = 0; i < 17; i++) begin
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL full_sb[%0d] got=%h exp=%h", i, got, e); end
      vectors++;
      if (oCh !== 2'(seqCh[i]) || oWrap !== logic'(i == 16)) begin
        miscompares++;
        $display("FAIL full_seq[%0d] ch=%0d wrap=%b exp ch=%0d wrap=%b", i, oCh, oWrap, seqCh[i], i == 16);
      end
    end
  endtask

  task automatic test_sparse();
    exp_t e;
    exp_t got;
    int seqCh[9] = '{1,1,1,1,3,3,3,3,1};
    iMode = 1'b0; iSel = 2'd0;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL sparse_pre_sb got=%h exp=%h", got, e); end
    iMode = 1'b1; iMask = 4'b1010;
    for (int i = 0; i < 14; i++) begin
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL sparse_sb[%0d] got=%h exp=%h", i, got, e); end
      if (i < 9) begin
        vectors++;
        if (oCh !== 2'(seqCh[i]) || oWrap !== logic'(i == 8)) begin
          miscompares++;
          $display("FAIL sparse_seq[%0d] ch=%0d wrap=%b exp ch=%0d wrap=%b", i, oCh, oWrap, seqCh[i], i == 8);
        end
      end
    end
    vectors++;
    if (oCh !== 2'd3) begin miscompares++; $display("FAIL sparse_ch3 ch=%0d exp=3", oCh); end
    iMask = 4'b0010;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL sparse_clear_sb got=%h exp=%h", got, e); end
    vectors++;
    if ({oCh, oWrap} !== {2'd1, 1'b1}) begin
      miscompares++; $display("FAIL sparse_clear ch=%0d wrap=%b exp ch=1 wrap=1", oCh, oWrap);
    end
  endtask

  task automatic test_hold_empty();
    exp_t e;
    exp_t got;
    int n1 = 0;
    iMode = 1'b0; iSel = 2'd0; iHold = 1'b0;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL hold_pre_sb got=%h exp=%h", got, e); end
    iMode = 1'b1; iMask = 4'hF;
    for (int i = 0; i < 14; i++) begin
      iHold = (i >= 6 && i <= 8);
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL hold_sb[%0d] got=%h exp=%h", i, got, e); end
      if (oCh == 2'd1) n1++;
    end
    vectors++;
    if (n1 !== 7) begin miscompares++; $display("FAIL hold_len got=%0d exp=7", n1); end
    iHold = 1'b0; iMask = 4'h0;
    for (int i = 0; i < 2; i++) begin
      iHold = (i == 1);
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL empty_sb[%0d] got=%h exp=%h", i, got, e); end
      vectors++;
      if ({oValid, oZ, oCh} !== {1'b0, 4'h0, 2'd2}) begin
        miscompares++; $display("FAIL empty[%0d] v=%b z=%h ch=%0d exp v=0 z=0 ch=2", i, oValid, oZ, oCh);
      end
    end
    iHold = 1'b0; iMask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL restore_sb[%0d] got=%h exp=%h", i, got, e); end
      vectors++;
      if ({oValid, oCh} !== {1'b1, (i < 4) ? 2'd2 : 2'd3}) begin
        miscompares++; $display("FAIL restore[%0d] v=%b ch=%0d exp v=1 ch=%0d", i, oValid, oCh, (i < 4) ? 2 : 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    exp_t got;
    iMode = 1'b0; iSel = 2'd0;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rmid_pre_sb got=%h exp=%h", got, e); end
    iMode = 1'b1; iMask = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rmid_sb[%0d] got=%h exp=%h", i, got, e); end
    end
    iReset = 1'b1;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== 8'h00 || e !== 8'h00) begin
      miscompares++; $display("FAIL rmid_reset got=%h exp=00", got);
    end
    iReset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rmid_after_sb[%0d] got=%h exp=%h", i, got, e); end
      vectors++;
      if ({oValid, oCh} !== {1'b1, (i < 4) ? 2'd0 : 2'd1}) begin
        miscompares++; $display("FAIL rmid_after[%0d] v=%b ch=%0d exp v=1 ch=%0d", i, oValid, oCh, (i < 4) ? 0 : 1);
      end
    end
  endtask

  task automatic test_dwell1();
    exp_t e;
    exp_t got;
    int seqCh[7] = '{0,1,2,0,1,1,1};
    int seqW[7]  = '{0,0,0,1,0,1,1};
    logic [11:0] d1;
    logic [3:0]  expZ;
    iMode1 = 1'b0; iSel1 = 2'd0; iData1 = 12'h987; d1 = iData1;
    tick();
    e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
    if (got !== e) begin miscompares++; $display("FAIL d1_pre_sb got=%h exp=%h", got, e); end
    iMode1 = 1'b1; iMask1 = 3'b111;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) iMask1 = 3'b010;
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL d1_u0_sb[%0d] got=%h exp=%h", i, got, e); end
      expZ = d1[seqCh[i]*4 +: 4];
      vectors++;
      if ({oCh1, oWrap1, oValid1, oZ1} !== {2'(seqCh[i]), 1'(seqW[i]), 1'b1, expZ}) begin
        miscompares++;
        $display("FAIL dwell1[%0d] ch=%0d w=%b v=%b z=%h exp ch=%0d w=%0d v=1 z=%h",
                 i, oCh1, oWrap1, oValid1, oZ1, seqCh[i], seqW[i], expZ);
      end
    end
    iMode1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    for (int i = 0; i < 400; i++) begin
      iReset = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) iMode = ~iMode;
      iMask = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom);
      iHold = ($urandom_range(3) == 0);
      iSel  = 2'($urandom);
      iData = 16'($urandom);
      tick();
      e = sbQ.pop_front(); got = {oZ, oCh, oValid, oWrap}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL random[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    iReset = 1'b1; iData = 16'h0; iSel = 2'd0; iMode = 1'b0; iMask = 4'h0; iHold = 1'b0;
    iData1 = 12'h987; iSel1 = 2'd0; iMode1 = 1'b0; iMask1 = 3'b111; iHold1 = 1'b0;
    test_reset();
    test_manual();
    test_scan_full();
    test_sparse();
    test_hold_empty();
    test_reset_mid();
    test_dwell1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/selector_scan.md
# selector_scan

Parametrised N-channel, W-bit registered data selector with two modes. In manual mode it selects a channel by index. In scan mode it steps automatically through the enabled channels, holding each for a fixed number of cycles. It generalises the team's 4-to-1, 4-bit combinational selector into a clocked block that feeds display/monitor paths, where several sources are shown in turn. All outputs are registered, with one cycle of latency.

## Interface
- WIDTH, 4: bits per channel (≥1)
- CHANNELS, 4: number of input channels (≥2; need not be a power of 2)
- DWELL, 4: edges each channel is presented in scan mode (≥1)
- SELW (localparam): max(1, clog2(CHANNELS))

Ports:
- iClk  in  1  single clock; all state updates on rising edge
- iReset  in  1  synchronous, active-high reset; highest priority
- iData  in  CHANNELS*WIDTH  packed inputs; channel k = iData[k*WIDTH +: WIDTH]
- iSel  in  SELW  manual channel index
- iMode  in  1  0 = manual, 1 = scan
- iMask  in  CHANNELS  scan enable per channel (bit k enables channel k); ignored in manual mode
- iHold  in  1  scan mode: freeze pointer and dwell count
- oZ  out  WIDTH  selected data, registered
- oCh  out  SELW  channel index currently presented
- oValid  out  1  1 when oZ carries a real channel
- oWrap  out  1  one-edge pulse when the scan pointer wraps

## Operation
- State registers: ptr (SELW bits, drives oCh), cnt (dwell count, range 1..DWELL), modeQ (registered iMode, used for entry detection).
- At every non-reset edge, oZ, oCh and oValid update together. When oValid = 1, oZ = iData slice of the new ptr, sampled at that edge. oZ keeps tracking live data even while the pointer is held.
- Reset (iReset = 1 at an edge): ptr=0, cnt=0, modeQ=0, oZ=0, oCh=0, oValid=0, oWrap=0. Reset overrides all other inputs.
- **MANUAL** (iMode = 0):
  - ptr ← iSel; cnt ← 0.
  - If iSel < CHANNELS: oValid ← 1, oZ ← channel iSel.
  - If iSel ≥ CHANNELS: oValid ← 0, oZ ← 0, oCh ← iSel.
  - oWrap ← 0.
- **SCAN** (iMode = 1):
  - next(p) is the lowest enabled channel strictly after p, searching upward modulo CHANNELS. If p is the only enabled channel, next(p) = p.
  - Empty mask (iMask = 0): ptr unchanged, cnt ← 0, oValid ← 0, oZ ← 0, oWrap ← 0.
  - Priority order within scan mode, evaluated at each edge:
    1. Entry edge (modeQ = 0), or cnt = 0, or iMask[ptr] = 0: ptr ← (iMask[ptr] ? ptr : next(ptr)); cnt ← 1. This rule applies even when iHold = 1.
    2. iHold = 1: ptr and cnt unchanged.
    3. cnt = DWELL: ptr ← next(ptr); cnt ← 1.
    4. Otherwise: cnt ← cnt + 1.
  - oWrap ← 1 exactly on edges where rule 1 or rule 3 moves ptr to a new index ≤ the old index. This includes a single-enabled-channel re-select at dwell expiry. All other edges: oWrap ← 0.
  - Mask changes take effect at the edge they are sampled. Enabling an earlier channel mid-dwell does not shorten the current dwell.
- Mode switch scan→manual: iSel is taken at that same edge. Manual→scan: handled by the entry rule (rule 1), starting from the current ptr.

## Timing
- Latency: input sampled at edge t appears on outputs after edge t; no combinational input-to-output path.
- With no hold and an unchanged mask, each enabled channel is presented for exactly DWELL consecutive edges. DWELL = 1 advances every edge.
- iHold asserted for H edges extends the current channel's presentation by H edges.
- Hold during an empty mask: outputs stay oValid=0, oZ=0. The first edge with a non-empty mask applies rule 1.

## Test plan
- **Reset:** iReset=1 for 2 edges with iData=16'hDCBA, iMode=1, iMask=4'hF → oZ=0, oCh=0, oValid=0, oWrap=0. Release → first edge gives oCh=0, oZ=A, oValid=1.
- **Manual:** iData=16'hDCBA, iSel=2 → oZ=C, oCh=2, oValid=1 one edge later. Ch2 data changes to 5 → oZ=5 next edge. Second build with CHANNELS=3, iSel=3 → oValid=0, oZ=0.
- **Scan, full mask:** DWELL=4, iMask=4'hF → oCh sequence 0,0,0,0,1,1,1,1,2×4,3×4,0. oWrap=1 only on the 3→0 edge.
- **Sparse mask:** iMask=4'b1010, entering scan with ptr=0 → oCh 1×4, 3×4, 1 with oWrap on 3→1. Clearing iMask[3] on the second edge of ch3 → next edge oCh=1, oWrap=1.
- **Hold and empty mask:** iHold=1 for 3 edges during ch1's second edge → ch1 shown for 7 edges total. Then iMask=0 → oValid=0, oZ=0, oCh unchanged. Restore 4'hF → oValid=1, the old ptr is kept if enabled, and cnt restarts.
- **Reset mid-scan:** iReset=1 on ch2 at cnt=2 → all outputs 0 next edge. Release with iMode=1 → scan restarts at ch0 for a full DWELL.
